// File: rtl/spi_stream_fetcher.sv
// spi_stream_fetcher: SPI fetch sequencer with fuzzy sync-header hunt and per-channel payload demux
module spi_stream_fetcher #(
  parameter int WORD_W = 8,
  parameter int CMD_W = 8,
  parameter logic [CMD_W-1:0] CMD = 8'hAA,
  parameter int HDR_W = 8,
  parameter logic [HDR_W-1:0] HEADER = 8'hFF,
  parameter int HDR_TOL = 1,
  parameter int NUM_CH = 2,
  parameter int LEN_W = 16,
  parameter int HUNT_MAX = 4096
) (
  input  logic                    CLK_40,
  input  logic                    reset,
  input  logic                    SPI_clk_en,
  input  logic                    start,
  input  logic                    frame_done,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  input  logic [NUM_CH-1:0]       ch_full,
  input  logic                    MISO,
  output logic                    MOSI,
  output logic                    chip_select,
  output logic [WORD_W-1:0]       wr_data,
  output logic [NUM_CH-1:0]       wr_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err_timeout
);
  localparam int CH_W = $clog2(NUM_CH + 1);
  localparam int HC_W = $clog2(HUNT_MAX + 1);
  localparam int BC_W = $clog2((CMD_W > WORD_W ? CMD_W : WORD_W) + 1);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_HUNT, S_RECV, S_FIN} state_t;
  state_t state, state_n;
  logic [BC_W-1:0] bit_cnt;
  logic [HDR_W-1:0] sreg, sreg_n;
  logic [WORD_W-1:0] shift_word;
  logic [LEN_W-1:0] lens [NUM_CH];
  logic [LEN_W-1:0] word_cnt, cur_len;
  logic [CH_W-1:0] ch, first_nz, next_nz;
  logic [HC_W-1:0] hunt_cnt;
  logic [CMD_W-1:0] cmd_sh;
  logic pend, cur_full, match, cmd_last, word_last, hunt_last, ch_end;
  assign sreg_n = {sreg[HDR_W-2:0], MISO};
  assign match = $countones(~(sreg_n ^ HEADER)) >= HDR_W - HDR_TOL;
  assign cmd_sh = CMD << bit_cnt;
  assign cmd_last = bit_cnt == BC_W'(CMD_W - 1);
  assign word_last = bit_cnt == BC_W'(WORD_W - 1);
  assign hunt_last = hunt_cnt == HC_W'(HUNT_MAX - 1);
  assign ch_end = word_cnt + LEN_W'(1) == cur_len || cur_full;
  assign MOSI = state == S_CMD && cmd_sh[CMD_W-1];
  assign chip_select = !(state inside {S_CMD, S_HUNT, S_RECV});
  assign busy = state != S_IDLE;
  // ch == NUM_CH means every channel has ended; zero-length channels are skipped
  always_comb begin
    first_nz = CH_W'(NUM_CH);
    next_nz = CH_W'(NUM_CH);
    cur_len = '0;
    cur_full = 1'b0;
    wr_en = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      first_nz = lens[c] != '0 ? CH_W'(c) : first_nz;
      next_nz = lens[c] != '0 && CH_W'(c) > ch ? CH_W'(c) : next_nz;
      cur_len = CH_W'(c) == ch ? lens[c] : cur_len;
      cur_full = CH_W'(c) == ch ? ch_full[c] : cur_full;
      wr_en[c] = pend && state == S_RECV && CH_W'(c) == ch;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = start || frame_done ? S_CMD : S_IDLE;
      S_CMD:  state_n = SPI_clk_en && cmd_last ? S_HUNT : S_CMD;
      S_HUNT: state_n = !SPI_clk_en ? S_HUNT : match ? S_RECV : hunt_last ? S_IDLE : S_HUNT;
      S_RECV: state_n = SPI_clk_en && ch == CH_W'(NUM_CH) ? S_FIN : S_RECV;
      S_FIN:  state_n = SPI_clk_en ? S_IDLE : S_FIN;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state <= S_IDLE;
      bit_cnt <= '0;
      sreg <= '0;
      shift_word <= '0;
      word_cnt <= '0;
      ch <= '0;
      hunt_cnt <= '0;
      pend <= 1'b0;
      wr_data <= '0;
      done <= 1'b0;
      err_timeout <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) lens[c] <= '0;
    end else begin
      state <= state_n;
      done <= state == S_RECV && state_n == S_FIN;
      err_timeout <= state == S_HUNT && state_n == S_IDLE;
      pend <= 1'b0;
      if (state == S_IDLE && state_n == S_CMD) begin
        for (int c = 0; c < NUM_CH; c++) lens[c] <= ch_len[c*LEN_W +: LEN_W];
        bit_cnt <= '0;
        word_cnt <= '0;
        hunt_cnt <= '0;
        ch <= '0;
      end
      if (SPI_clk_en && state == S_CMD) begin
        bit_cnt <= cmd_last ? '0 : bit_cnt + 1'b1;
        sreg <= '0;
      end
      if (SPI_clk_en && state == S_HUNT) begin
        sreg <= sreg_n;
        hunt_cnt <= hunt_cnt + 1'b1;
        if (match) ch <= first_nz;
      end
      // the word is staged here and strobed in the following cycle via pend
      if (SPI_clk_en && state == S_RECV) begin
        shift_word <= {shift_word[WORD_W-2:0], MISO};
        bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
        if (word_last && ch != CH_W'(NUM_CH)) begin
          pend <= 1'b1;
          wr_data <= {shift_word[WORD_W-2:0], MISO};
        end
      end
      if (pend) begin
        word_cnt <= ch_end ? '0 : word_cnt + 1'b1;
        if (ch_end) ch <= next_nz;
      end
    end
  end
endmodule

// File: tb/tb_spi_stream_fetcher.sv
// tb_spi_stream_fetcher: directed and random fetches checked against a bit-stream reference model
`timescale 1ns/1ps
module tb_spi_stream_fetcher;
  localparam int HUNT_MAX = 64;
  logic CLK_40 = 1'b0;
  logic reset, SPI_clk_en, start, frame_done, MISO;
  logic [31:0] ch_len;
  logic [1:0] ch_full;
  logic MOSI, chip_select, busy, done, err_timeout;
  logic [7:0] wr_data;
  logic [1:0] wr_en;
  int checks = 0, passed = 0;
  bit bits[$];
  logic [9:0] got_q[$], exp_q[$];
  int idx, n_done, n_err, err_tick, n_video, bad, v0;
  logic [7:0] mosi_word;
  bit full_mode, poke;

  spi_stream_fetcher #(.HUNT_MAX(HUNT_MAX)) dut (
    .CLK_40(CLK_40), .reset(reset), .SPI_clk_en(SPI_clk_en), .start(start),
    .frame_done(frame_done), .ch_len(ch_len), .ch_full(ch_full), .MISO(MISO),
    .MOSI(MOSI), .chip_select(chip_select), .wr_data(wr_data), .wr_en(wr_en),
    .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #12.5 CLK_40 = ~CLK_40;

  always @(negedge CLK_40) begin
    if (wr_en != 2'b00) begin
      got_q.push_back({wr_en, wr_data});
      if (wr_en[0]) n_video++;
      if (!busy || !$onehot(wr_en)) bad++;
    end
    if (done === 1'b1) n_done++;
    if (err_timeout === 1'b1) begin
      n_err++;
      err_tick = idx;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit bit_at(input int i);
    return i < bits.size() ? bits[i] : 1'b0;
  endfunction

  function automatic logic [7:0] byte_at(input int p);
    logic [7:0] b = '0;
    for (int i = 0; i < 8; i++) b = {b[6:0], bit_at(p + i)};
    return b;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endtask

  task automatic prep(input int zeros, input logic [7:0] hdr);
    bits.delete();
    repeat (8) bits.push_back(1'($urandom_range(0, 1)));
    repeat (zeros) bits.push_back(1'b0);
    push_byte(hdr);
  endtask

  task automatic tick();
    @(negedge CLK_40);
    MISO = bit_at(idx);
    start = poke && idx == 20;
    SPI_clk_en = 1'b1;
    if (idx < 8) mosi_word = {mosi_word[6:0], MOSI};
    idx++;
    repeat ($urandom_range(1, 3)) begin
      @(negedge CLK_40);
      SPI_clk_en = 1'b0;
      start = 1'b0;
      ch_full[0] = full_mode && n_video - v0 >= 1;
    end
  endtask

  task automatic run_txn(input int l0, input int l1, input bit fm, input bit pk, input bit fd, input bit abort);
    int m, p, n0, d0, e0, g0, b0;
    logic [7:0] w;
    full_mode = fm;
    poke = pk;
    mosi_word = '0;
    idx = 0;
    ch_len = {16'(l1), 16'(l0)};
    ch_full = '0;
    // sync is the first hunt tick whose last 8 bits (zeros before the hunt) agree with 8'hFF in >= 7 places
    m = -1;
    w = '0;
    for (int i = 0; i < HUNT_MAX; i++) begin
      w = {w[6:0], bit_at(8 + i)};
      if ($countones(~(w ^ 8'hFF)) >= 7) begin
        m = 8 + i;
        break;
      end
    end
    exp_q.delete();
    p = m + 1;
    n0 = fm && l0 > 2 ? 2 : l0;
    if (m >= 0) begin
      for (int k = 0; k < n0; k++) begin exp_q.push_back({2'b01, byte_at(p)}); p += 8; end
      for (int k = 0; k < l1; k++) begin exp_q.push_back({2'b10, byte_at(p)}); p += 8; end
    end
    d0 = n_done; e0 = n_err; g0 = got_q.size(); b0 = bad; v0 = n_video;
    @(negedge CLK_40);
    if (fd) frame_done = 1'b1; else start = 1'b1;
    @(negedge CLK_40);
    start = 1'b0;
    frame_done = 1'b0;
    if (abort) begin
      while (got_q.size() == g0 && idx < 400) tick();
      @(negedge CLK_40);
      SPI_clk_en = 1'b0;
      reset = 1'b1;
      @(negedge CLK_40);
      check("abort_cs", chip_select, 1);
      check("abort_busy", busy, 0);
      check("abort_wr_en", wr_en, 0);
      reset = 1'b0;
      repeat (40) @(negedge CLK_40);
      check("abort_writes", got_q.size() - g0, 1);
      return;
    end
    while (n_done == d0 && n_err == e0 && idx < 400) tick();
    tick();
    tick();
    check("mosi_cmd", mosi_word, 8'hAA);
    if (m < 0) begin
      check("timeout_pulses", n_err - e0, 1);
      check("timeout_tick", err_tick, 8 + HUNT_MAX);
      check("timeout_writes", got_q.size() - g0, 0);
      check("timeout_done", n_done - d0, 0);
    end else begin
      check("done_pulses", n_done - d0, 1);
      check("no_timeout", n_err - e0, 0);
      check("write_count", got_q.size() - g0, exp_q.size());
      foreach (exp_q[k]) check($sformatf("write%0d", k), got_q[g0 + k], exp_q[k]);
    end
    check("strobe_onehot_busy", bad - b0, 0);
    check("cs_idle", chip_select, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    int g;
    reset = 1'b1; SPI_clk_en = 1'b0; start = 1'b0; frame_done = 1'b0; MISO = 1'b0;
    ch_len = '0; ch_full = '0; full_mode = 1'b0; poke = 1'b0; idx = 0; v0 = 0;
    repeat (3) @(negedge CLK_40);
    check("rst_mosi", MOSI, 0);
    check("rst_cs", chip_select, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err_timeout, 0);
    reset = 1'b0;
    repeat (2) @(negedge CLK_40);
    prep(4, 8'hFF);
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56);
    push_byte(8'h78); push_byte(8'h9A); push_byte(8'hBC);
    run_txn(4, 2, 0, 0, 0, 0);
    prep(3, 8'hEF);
    push_byte(8'h12); push_byte(8'h34);
    g = got_q.size();
    run_txn(1, 1, 0, 0, 1, 0);
    check("ef_first_word", got_q[g], {2'b01, 8'h12});
    check("ef_second_word", got_q[g + 1], {2'b10, 8'h34});
    prep(2, 8'hE7);
    run_txn(4, 2, 0, 0, 0, 0);
    prep(1, 8'hEF);
    repeat (6) push_byte(8'($urandom));
    run_txn(4, 2, 1, 0, 0, 0);
    prep(5, 8'hEF);
    repeat (3) push_byte(8'($urandom));
    run_txn(0, 3, 0, 0, 0, 0);
    prep(2, 8'hEF);
    repeat (6) push_byte(8'($urandom));
    run_txn(3, 2, 0, 0, 0, 1);
    prep(2, 8'hFF);
    repeat (6) push_byte(8'($urandom));
    run_txn(3, 2, 0, 0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      int sel = $urandom_range(0, 2);
      prep($urandom_range(0, 6), sel == 0 ? 8'hFF : sel == 1 ? 8'hEF : 8'($urandom));
      repeat (10) push_byte(8'($urandom));
      run_txn($urandom_range(1, 4), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1, t[0], 0);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
